irq_sequencer: RTL

- Interrupt controller that sits in front of the PC register and decides when it is redirected.
- Latches rising edges on external interrupt lines into a pending register, masks and priority-arbitrates them, and issues a one-cycle take pulse that drives the PC register's interrupt input.
- Saves the return PC (epc) and cause, blocks nesting while a handler runs, and sequences the return when the handler executes mret.

---
 rtl/irq_sequencer_pkg.sv | 12 +
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/irq_sequencer_pkg.sv
// Shared constants for the interrupt sequencer: default vector, FSM encodings, cause width.
package irq_sequencer_pkg;

    localparam int unsigned CAUSE_W    = 4;
    localparam logic [31:0] VEC_PC_DEF = 32'h1C09_0000;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_RETURN  = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Ports:
//   req   - request vector
//   valid - any request set
//   idx   - index of the lowest set request (0 when none)
module irq_prio_enc
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    output logic               valid,
    output logic [CAUSE_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer in front of the PC register: edge-latches requests,
// masks and arbitrates them, issues the take pulse, saves epc/cause and
// sequences the mret return. Nesting is blocked while a handler runs.
// Ports:
//   clk, rst_n         - clock, async active-low reset
//   irq_req            - level request lines
//   mask_we/mask_wdata - mask register write (1 = enabled)
//   stall              - pipeline cannot take a redirect this cycle
//   next_pc            - return address captured on take
//   mret               - handler return retiring
//   int_take/vec_pc    - interrupt redirect pulse and handler address
//   ret_take/ret_pc    - return redirect pulse and address
//   epc, cause         - saved return address and taken index
//   in_handler         - handler running
//   pending            - pending request register
module irq_sequencer
    import irq_sequencer_pkg::*;
#(
    parameter int unsigned       N_IRQ    = 4,
    parameter logic [31:0]       VEC_PC   = VEC_PC_DEF,
    parameter logic [N_IRQ-1:0]  MASK_RST = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_IRQ-1:0]   irq_req,
    input  logic               mask_we,
    input  logic [N_IRQ-1:0]   mask_wdata,
    input  logic               stall,
    input  logic [31:0]        next_pc,
    input  logic               mret,
    output logic               int_take,
    output logic [31:0]        vec_pc,
    output logic               ret_take,
    output logic [31:0]        ret_pc,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_handler,
    output logic [N_IRQ-1:0]   pending
);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [N_IRQ-1:0]   prev_req;
    logic [N_IRQ-1:0]   mask;
    logic [N_IRQ-1:0]   eligible;
    logic [N_IRQ-1:0]   rise;
    logic [N_IRQ-1:0]   clr;
    logic               win_valid;
    logic [CAUSE_W-1:0] win_idx;
    logic               take;
    logic               ret;

    assign vec_pc   = VEC_PC;
    assign ret_pc   = epc;
    assign eligible = pending & mask;
    assign rise     = irq_req & ~prev_req;
    assign clr      = take ? (N_IRQ'(1) << win_idx) : '0;

    irq_prio_enc #(.N(N_IRQ)) u_prio (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pulse triggers; takes only from IDLE so a return never collides
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        ret       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid && !stall) begin
                    take      = 1'b1;
                    state_nxt = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (mret) begin
                    ret       = 1'b1;
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; a new edge beats the take clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_req   <= '0;
            pending    <= '0;
            mask       <= MASK_RST;
            epc        <= '0;
            cause      <= '0;
            int_take   <= 1'b0;
            ret_take   <= 1'b0;
            in_handler <= 1'b0;
        end else begin
            prev_req   <= irq_req;
            pending    <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
            if (take) begin
                epc   <= next_pc;
                cause <= win_idx;
            end
            int_take   <= take;
            ret_take   <= ret;
            in_handler <= (state_nxt == ST_HANDLER);
        end
    end

endmodule
